countreg_frame_tx: RTL and testbench

COUNTREG_FRAME_TX -- requirements
Module: countreg_frame_tx

---
 rtl/countreg_frame_tx_pkg.sv | 30 +++
 rtl/countreg_frame_tx_if.sv | 36 +++
 rtl/countreg_frame_tx_bitmap_store.sv | 39 +++
 rtl/countreg_frame_tx.sv | 107 ++++++++++
 tb/tb_countreg_frame_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/countreg_frame_tx_pkg.sv
// Shared sizing constants and FSM encoding for the count-register frame transmitter.
package countreg_frame_tx_pkg;

    localparam int NUM_SLOTS      = 8;
    localparam int NUM_ROUNDS     = 4;
    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 64;
    localparam int INDEX_W        = 11;

    localparam int NUM_WORDS      = NUM_ROUNDS * NUM_SLOTS;
    localparam int WORD_ADDR_W    = 5;
    localparam int BIT_W          = 6;

    // FSM state encoding
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_SEND    = 1'b1;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [WORD_ADDR_W-1:0] word_addr_t;

    // Word address is {round, slot}, i.e. the upper bits of the index.
    function automatic word_addr_t index_word(input logic [INDEX_W-1:0] idx);
        return idx[INDEX_W-1:BIT_W];
    endfunction

    function automatic logic [BIT_W-1:0] index_bit(input logic [INDEX_W-1:0] idx);
        return idx[BIT_W-1:0];
    endfunction

endpackage

// File: rtl/countreg_frame_tx_if.sv
// Collection/transmit bus of the count-register frame transmitter.
interface countreg_frame_tx_if;
    import countreg_frame_tx_pkg::*;

    logic               i_index_valid;
    logic [INDEX_W-1:0] i_index;
    logic               i_frame_end;
    logic               o_ready;
    logic [7:0]         o_countreg_0;
    logic [7:0]         o_countreg_1;
    logic [7:0]         o_countreg_2;
    logic [7:0]         o_countreg_3;
    logic [7:0]         o_countreg_4;
    logic [7:0]         o_countreg_5;
    logic [7:0]         o_countreg_6;
    logic [7:0]         o_countreg_7;
    logic               o_countreg_valid;
    logic               o_frame_done;

    modport master (
        output i_index_valid, i_index, i_frame_end,
        input  o_ready,
        input  o_countreg_0, o_countreg_1, o_countreg_2, o_countreg_3,
        input  o_countreg_4, o_countreg_5, o_countreg_6, o_countreg_7,
        input  o_countreg_valid, o_frame_done
    );

    modport slave (
        input  i_index_valid, i_index, i_frame_end,
        output o_ready,
        output o_countreg_0, o_countreg_1, o_countreg_2, o_countreg_3,
        output o_countreg_4, o_countreg_5, o_countreg_6, o_countreg_7,
        output o_countreg_valid, o_frame_done
    );

endinterface

// File: rtl/countreg_frame_tx_bitmap_store.sv
// 32 x 64-bit bitmap with a single-bit set port and a clear-on-read word port.
module countreg_bitmap_store
    import countreg_frame_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic               rd_en,
    input  word_addr_t         rd_addr,
    output word_t              rd_word
);

    word_t words_q [NUM_WORDS];
    word_t words_d [NUM_WORDS];

    assign rd_word = words_q[rd_addr];

    // Next bitmap: clear the word being read, then OR in the requested bit.
    always_comb begin
        words_d = words_q;
        if (rd_en) begin
            words_d[rd_addr] = '0;
        end
        if (set_en) begin
            words_d[index_word(set_idx)][index_bit(set_idx)] = 1'b1;
        end
    end

    // Bitmap storage, wiped by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '{default: '0};
        end else begin
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/countreg_frame_tx.sv
// Collects bitmap indices, then streams the 32 bitmap words out as registered bytes.
module countreg_frame_tx
    import countreg_frame_tx_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    countreg_frame_tx_if.slave  bus
);

    logic [0:0] state_q, state_d;
    word_addr_t beat_q,  beat_d;
    logic       drain_q, drain_d;
    word_t      cr_q,    cr_d;
    logic       valid_q, valid_d;
    logic       done_q,  done_d;

    logic       set_en;
    logic       rd_en;
    word_t      rd_word;

    countreg_bitmap_store u_store (
        .clk     (i_clk),
        .rst     (i_rst),
        .set_en  (set_en),
        .set_idx (bus.i_index),
        .rd_en   (rd_en),
        .rd_addr (beat_q),
        .rd_word (rd_word)
    );

    // FSM: COLLECT accepts indices; SEND reads one word per cycle, then spends
    // one drain cycle so beat 31 is shown before returning with frame_done.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        cr_d    = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        set_en  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                set_en = bus.i_index_valid;
                if (bus.i_frame_end) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                    drain_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (!drain_q) begin
                    rd_en   = 1'b1;
                    cr_d    = rd_word;
                    valid_d = (beat_q[2:0] == 3'd0);
                    if (beat_q == word_addr_t'(NUM_WORDS - 1)) begin
                        drain_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_COLLECT;
                    drain_d = 1'b0;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                beat_d  = '0;
                drain_d = 1'b0;
            end
        endcase
    end

    // Control and registered output state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_COLLECT;
            beat_q  <= '0;
            drain_q <= 1'b0;
            cr_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            cr_q    <= cr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_ready          = (state_q == ST_COLLECT);
    assign bus.o_countreg_valid = valid_q;
    assign bus.o_frame_done     = done_q;
    assign bus.o_countreg_0     = cr_q[7:0];
    assign bus.o_countreg_1     = cr_q[15:8];
    assign bus.o_countreg_2     = cr_q[23:16];
    assign bus.o_countreg_3     = cr_q[31:24];
    assign bus.o_countreg_4     = cr_q[39:32];
    assign bus.o_countreg_5     = cr_q[47:40];
    assign bus.o_countreg_6     = cr_q[55:48];
    assign bus.o_countreg_7     = cr_q[63:56];

endmodule

// File: tb/tb_countreg_frame_tx.sv
// Directed bench for countreg_frame_tx: one task per scenario, inline checks.
module tb_countreg_frame_tx;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    countreg_frame_tx_if bus ();

    countreg_frame_tx dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] cap_word  [32];
    logic        cap_valid [32];
    logic        cap_ready [32];
    logic        cap_done  [32];
    logic        done_after;
    logic        ready_after;
    logic        done_after2;

    function automatic logic [63:0] out_word();
        return {bus.o_countreg_7, bus.o_countreg_6, bus.o_countreg_5, bus.o_countreg_4,
                bus.o_countreg_3, bus.o_countreg_2, bus.o_countreg_1, bus.o_countreg_0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_index(input logic [10:0] idx);
        bus.i_index_valid = 1'b1;
        bus.i_index       = idx;
        tick();
        bus.i_index_valid = 1'b0;
        bus.i_index       = '0;
    endtask

    // Pulse frame_end and capture the 32 beats plus the frame_done cycle.
    task automatic run_frame(input bit inject);
        bus.i_frame_end = 1'b1;
        tick();
        bus.i_frame_end = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (inject) begin
                bus.i_index_valid = 1'b1;
                bus.i_index       = 11'd5;
                bus.i_frame_end   = 1'b1;
            end
            tick();
            cap_word[b]  = out_word();
            cap_valid[b] = bus.o_countreg_valid;
            cap_ready[b] = bus.o_ready;
            cap_done[b]  = bus.o_frame_done;
        end
        bus.i_index_valid = 1'b0;
        bus.i_index       = '0;
        bus.i_frame_end   = 1'b0;
        tick();
        done_after  = bus.o_frame_done;
        ready_after = bus.o_ready;
        tick();
        done_after2 = bus.o_frame_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_index_valid = 1'b0;
        bus.i_index       = '0;
        bus.i_frame_end   = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready);
        end
        checks++;
        if (bus.o_countreg_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.o_countreg_valid);
        end
        checks++;
        if (bus.o_frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", bus.o_frame_done);
        end
        checks++;
        if (out_word() !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", out_word());
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_index0();
        logic [63:0] exp [32];
        for (int b = 0; b < 32; b++) exp[b] = 64'h0;
        exp[0] = 64'h01;
        set_index(11'd0);
        run_frame(1'b0);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== exp[b]) begin
                errors++; $display("FAIL idx0_beat%0d: got %h want %h", b, cap_word[b], exp[b]);
            end
            checks++;
            if (cap_valid[b] !== ((b % 8) == 0)) begin
                errors++; $display("FAIL idx0_valid%0d: got %b want %b", b, cap_valid[b], (b % 8) == 0);
            end
            checks++;
            if (cap_ready[b] !== 1'b0 || cap_done[b] !== 1'b0) begin
                errors++; $display("FAIL idx0_ctl%0d: got ready=%b done=%b want 0 0", b, cap_ready[b], cap_done[b]);
            end
        end
        checks++;
        if (done_after !== 1'b1 || ready_after !== 1'b1) begin
            errors++; $display("FAIL idx0_done: got done=%b ready=%b want 1 1", done_after, ready_after);
        end
        checks++;
        if (done_after2 !== 1'b0) begin
            errors++; $display("FAIL idx0_done_len: got %b want 0", done_after2);
        end
    endtask

    task automatic test_index_max();
        set_index(11'd2047);
        run_frame(1'b0);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== ((b == 31) ? 64'h8000_0000_0000_0000 : 64'h0)) begin
                errors++; $display("FAIL max_beat%0d: got %h", b, cap_word[b]);
            end
            checks++;
            if (cap_valid[b] !== ((b % 8) == 0)) begin
                errors++; $display("FAIL max_valid%0d: got %b want %b", b, cap_valid[b], (b % 8) == 0);
            end
        end
        checks++;
        if (done_after !== 1'b1) begin
            errors++; $display("FAIL max_done: got %b want 1", done_after);
        end
    endtask

    task automatic test_idempotent();
        set_index(11'h245);
        set_index(11'h245);
        set_index(11'h245);
        set_index(11'h246);
        run_frame(1'b0);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== ((b == 9) ? 64'h60 : 64'h0)) begin
                errors++; $display("FAIL idem_beat%0d: got %h", b, cap_word[b]);
            end
        end
    endtask

    task automatic test_same_cycle();
        bus.i_index_valid = 1'b1;
        bus.i_index       = 11'd7;
        run_frame(1'b0);
        checks++;
        if (cap_word[0] !== 64'h80) begin
            errors++; $display("FAIL same_cycle_beat0: got %h want 80", cap_word[0]);
        end
    endtask

    task automatic test_drop_in_send();
        int extra;
        run_frame(1'b1);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== 64'h0 || cap_ready[b] !== 1'b0) begin
                errors++; $display("FAIL drop_beat%0d: got %h ready=%b want 0 0", b, cap_word[b], cap_ready[b]);
            end
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.o_ready !== 1'b1 || bus.o_countreg_valid !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL drop_no_queue: got %0d busy cycles want 0", extra);
        end
        run_frame(1'b0);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== 64'h0) begin
                errors++; $display("FAIL drop_next_beat%0d: got %h want 0", b, cap_word[b]);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int bad;
        set_index(11'd1280);
        bus.i_frame_end = 1'b1;
        tick();
        bus.i_frame_end = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_countreg_valid !== 1'b0 || out_word() !== 64'h0) begin
            errors++; $display("FAIL abort_async: got ready=%b valid=%b data=%h want 1 0 0",
                               bus.o_ready, bus.o_countreg_valid, out_word());
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.o_frame_done !== 1'b0 || bus.o_countreg_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
        set_index(11'd100);
        run_frame(1'b0);
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (cap_word[b] !== ((b == 1) ? 64'h0000_0010_0000_0000 : 64'h0)) begin
                errors++; $display("FAIL abort_next_beat%0d: got %h", b, cap_word[b]);
            end
        end
        checks++;
        if (done_after !== 1'b1) begin
            errors++; $display("FAIL abort_next_done: got %b want 1", done_after);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.i_index_valid = 1'b0;
        bus.i_index       = '0;
        bus.i_frame_end   = 1'b0;
        test_reset();
        test_index0();
        test_index_max();
        test_idempotent();
        test_same_cycle();
        test_drop_in_send();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
